pwm_dt_multi: RTL and testbench
===============================

PWM_DT_MULTI -- requirements
Module: pwm_dt_multi

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the deadtime counter and preload width.
REQ-002 The block SHALL have parameter NCH, default 3, giving the number of complementary channels.
REQ-003 clk_psc_i  in  1  SHALL be the single prescaled timer clock; all state changes on its rising edge.
REQ-004 rst_n_i  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 update_event_i  in  1  SHALL be the timer update strobe that loads all shadow registers.
REQ-006 pwm_in_i  in  NCH  SHALL be the raw per-channel PWM references.
REQ-007 dtg_rise_preload_i  in  WIDTH  SHALL be the rising-edge deadtime preload, shared by all channels.
REQ-008 dtg_fall_preload_i  in  WIDTH  SHALL be the falling-edge deadtime preload, shared by all channels.
REQ-009 out_en_preload_i  in  NCH  SHALL be the per-channel output-enable preload.
REQ-010 break_i  in  1  SHALL be the break request (present only under PWM_DT_BREAK_EN).
REQ-011 pwm_high_o / pwm_low_o  out  NCH each  SHALL be the registered high-side and low-side gate drives.
REQ-012 dt_busy_o  out  NCH  SHALL flag channels currently inside a deadtime window.
REQ-013 break_latched_o  out  1  SHALL be the sticky break flag (present only under PWM_DT_BREAK_EN).

Function
REQ-014 Shadow registers dt_rise, dt_fall, out_en SHALL load from the preloads on any edge with update_event_i=1 and hold otherwise.
REQ-015 Each channel SHALL run one FSM: LOW (low_o=1), DT_RISE (both 0), HIGH (high_o=1), DT_FALL (both 0).
REQ-016 LOW: on an edge sampling pwm_in=1, the FSM SHALL go to HIGH if dt_rise=0, else to DT_RISE with counter loaded to dt_rise.
REQ-017 DT_RISE: the counter SHALL decrement each edge; the edge seeing counter=1 with pwm_in=1 SHALL enter HIGH.
REQ-018 With dt_rise=D>0, low_o SHALL fall on sample edge k and high_o SHALL rise on edge k+D (gap exactly D clocks, both outputs 0).
REQ-019 DT_RISE with pwm_in sampled 0 SHALL return to LOW at that edge (pulses shorter than deadtime swallowed).
REQ-020 HIGH/DT_FALL SHALL mirror REQ-016..019 using dt_fall, pwm_in=0 and low_o.
REQ-021 dt_busy_o SHALL be 1 exactly while the channel is in DT_RISE or DT_FALL.
REQ-022 A shadow update during a deadtime window SHALL NOT reload the running counter; new values apply from the next transition.
REQ-023 out_en=0 SHALL force that channel's high_o and low_o to 0 while its FSM continues tracking pwm_in.
REQ-024 high_o and low_o of one channel SHALL never both be 1 in any cycle, including bypass mode.
REQ-025 Counter arithmetic SHALL be unsigned WIDTH-bit with no wrap; dt value 2^WIDTH-1 gives the maximum gap.

Reset
REQ-026 During reset all FSMs SHALL be LOW, counters 0, shadows 0, and every output 0 (out_en shadow=0 masks low_o).
REQ-027 Reset asserted mid-deadtime SHALL immediately clear outputs and counters asynchronously.

Configuration
REQ-028 With macro PWM_DT_BREAK_EN defined, break_i sampled 1 SHALL drive all outputs to 0 on the next edge, force FSMs to LOW, clear counters and set break_latched_o.
REQ-029 With PWM_DT_BREAK_EN, outputs SHALL stay 0 while break_latched_o=1; it SHALL clear only on an update_event_i edge with break_i=0.
REQ-030 Without PWM_DT_BREAK_EN, break_i and break_latched_o SHALL be absent and no break logic built.

Structure
REQ-031 Package pwm_dt_pkg SHALL hold the channel state enum and the default WIDTH/NCH constants.
REQ-032 Per-channel FSM/counter SHALL be sub-module pwm_dt_channel, instantiated NCH times by generate; shadows and break logic stay in the top.

Verification
REQ-033 Reset then update with dt_rise=3, out_en=all 1: low_o=1, high_o=0 on all channels after first post-update edge.
REQ-034 Ch0 pwm_in 0->1: low_o[0] falls next edge, high_o[0] rises exactly 3 clocks later, dt_busy_o[0]=1 for those 3 cycles.
REQ-035 dt_fall=5, ch1 pwm_in 1->0: 5-clock both-off gap; a 2-clock pwm_in pulse on ch2 with dt_rise=3 produces no high_o[2].
REQ-036 dt_rise=dt_fall=0: outputs follow pwm_in with 1-clock latency, never both 1.
REQ-037 Update dt_rise 3->7 mid-window: current gap remains 3, next rising gap is 7; out_en[1]=0 zeroes ch1 only.
REQ-038 PWM_DT_BREAK_EN: break_i pulse mid-HIGH zeroes all outputs next edge; latch holds until update_event_i with break_i=0.

Source files
------------

// File: rtl/pwm_dt_pkg.sv
// Shared types and default sizing for the multi-channel deadtime generator.
package pwm_dt_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 3;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_DT_RISE = 2'd1,
    ST_HIGH    = 2'd2,
    ST_DT_FALL = 2'd3
  } ch_state_e;
endpackage

// File: rtl/pwm_dt_channel.sv
// One complementary channel: tracks its PWM reference and inserts rise/fall deadtime.
module pwm_dt_channel
  import pwm_dt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             halt,
  input  logic             pwm_in,
  input  logic [WIDTH-1:0] dt_rise,
  input  logic [WIDTH-1:0] dt_fall,
  input  logic             en,
  output logic             high,
  output logic             low,
  output logic             busy
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  ch_state_e        state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter is only loaded on entry to a window, so shadow updates
  // that land mid-window do not disturb the gap already in progress.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_LOW: if (pwm_in) begin
        if (dt_rise == '0) state_nxt = ST_HIGH;
        else begin
          state_nxt = ST_DT_RISE;
          cnt_nxt   = dt_rise;
        end
      end
      ST_DT_RISE: begin
        if (!pwm_in) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end else if (cnt <= ONE) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt - ONE;
      end
      ST_HIGH: if (!pwm_in) begin
        if (dt_fall == '0) state_nxt = ST_LOW;
        else begin
          state_nxt = ST_DT_FALL;
          cnt_nxt   = dt_fall;
        end
      end
      ST_DT_FALL: begin
        if (pwm_in) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else if (cnt <= ONE) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt - ONE;
      end
      default: begin
        state_nxt = ST_LOW;
        cnt_nxt   = '0;
      end
    endcase
    if (halt) begin
      state_nxt = ST_LOW;
      cnt_nxt   = '0;
    end
  end

  // Single-state decode keeps high and low mutually exclusive by construction.
  assign high = en && (state == ST_HIGH);
  assign low  = en && (state == ST_LOW);
  assign busy = (state == ST_DT_RISE) || (state == ST_DT_FALL);
endmodule

// File: rtl/pwm_dt_multi.sv
// Multi-channel complementary PWM with shared deadtime shadows.
// Optional break input and sticky latch built when PWM_DT_BREAK_EN is defined.
module pwm_dt_multi
  import pwm_dt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             update_event_i,
  input  logic [NCH-1:0]   pwm_in_i,
  input  logic [WIDTH-1:0] dtg_rise_preload_i,
  input  logic [WIDTH-1:0] dtg_fall_preload_i,
  input  logic [NCH-1:0]   out_en_preload_i,
`ifdef PWM_DT_BREAK_EN
  input  logic             break_i,
  output logic             break_latched_o,
`endif
  output logic [NCH-1:0]   pwm_high_o,
  output logic [NCH-1:0]   pwm_low_o,
  output logic [NCH-1:0]   dt_busy_o
);
  logic [WIDTH-1:0] dt_rise, dt_fall;
  logic [NCH-1:0]   out_en, en_eff;
  logic             halt;

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dt_rise <= '0;
      dt_fall <= '0;
      out_en  <= '0;
    end else if (update_event_i) begin
      dt_rise <= dtg_rise_preload_i;
      dt_fall <= dtg_fall_preload_i;
      out_en  <= out_en_preload_i;
    end
  end

`ifdef PWM_DT_BREAK_EN
  logic brk_lat;

  // A break in the same cycle as an update wins; only a clean update clears.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i)            brk_lat <= 1'b0;
    else if (break_i)        brk_lat <= 1'b1;
    else if (update_event_i) brk_lat <= 1'b0;
  end

  assign halt            = break_i;
  assign en_eff          = out_en & {NCH{~brk_lat}};
  assign break_latched_o = brk_lat;
`else
  assign halt   = 1'b0;
  assign en_eff = out_en;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_dt_channel #(.WIDTH(WIDTH)) u_ch (
      .clk_psc_i (clk_psc_i),
      .rst_n_i   (rst_n_i),
      .halt      (halt),
      .pwm_in    (pwm_in_i[g]),
      .dt_rise   (dt_rise),
      .dt_fall   (dt_fall),
      .en        (en_eff[g]),
      .high      (pwm_high_o[g]),
      .low       (pwm_low_o[g]),
      .busy      (dt_busy_o[g])
    );
  end
endmodule

// File: tb/tb_pwm_dt_multi.sv
// Randomized bench for pwm_dt_multi against a run-length deadtime model.
module tb_pwm_dt_multi;
  localparam int W = 8;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         upd;
  logic [N-1:0] pwm;
  logic [W-1:0] rise_pre, fall_pre;
  logic [N-1:0] en_pre;
  logic         break_i;
  logic         brk_lat;
  logic [N-1:0] high, low, busy;

  always #5 clk = ~clk;

  pwm_dt_multi #(.WIDTH(W), .NCH(N)) dut (
    .clk_psc_i          (clk),
    .rst_n_i            (rst_n),
    .update_event_i     (upd),
    .pwm_in_i           (pwm),
    .dtg_rise_preload_i (rise_pre),
    .dtg_fall_preload_i (fall_pre),
    .out_en_preload_i   (en_pre),
`ifdef PWM_DT_BREAK_EN
    .break_i            (break_i),
    .break_latched_o    (brk_lat),
`endif
    .pwm_high_o         (high),
    .pwm_low_o          (low),
    .dt_busy_o          (busy)
  );
`ifndef PWM_DT_BREAK_EN
  assign brk_lat = 1'b0;
`endif

  // Model: each channel has a settled side and the length of the current run
  // of opposite samples; the side flips once that run exceeds the deadtime
  // captured when the run started.
  int           side [N];
  int           run  [N];
  int           dcap [N];
  int           m_rise, m_fall;
  logic [N-1:0] m_en;
  bit           m_lat;
  int           n_chk = 0, n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin side[c] = 0; run[c] = 0; dcap[c] = 0; end
    m_rise = 0; m_fall = 0; m_en = '0; m_lat = 0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      int p;
      p = int'(pwm[c]);
      if (break_i) begin
        side[c] = 0; run[c] = 0;
      end else if (p != side[c]) begin
        if (run[c] == 0) dcap[c] = p ? m_rise : m_fall;
        run[c]++;
        if (run[c] > dcap[c]) begin side[c] = p; run[c] = 0; end
      end else run[c] = 0;
    end
    if (upd) begin m_rise = int'(rise_pre); m_fall = int'(fall_pre); m_en = en_pre; end
    if (break_i) m_lat = 1;
    else if (upd) m_lat = 0;
  endtask

  task automatic check_outs();
    logic [N-1:0] eh, el, eb;
    for (int c = 0; c < N; c++) begin
      logic e;
      e     = m_en[c] && !m_lat;
      eh[c] = e && run[c] == 0 && side[c] == 1;
      el[c] = e && run[c] == 0 && side[c] == 0;
      eb[c] = run[c] != 0;
    end
    chk("high", 32'(high), 32'(eh));
    chk("low", 32'(low), 32'(el));
    chk("busy", 32'(busy), 32'(eb));
    chk("overlap", 32'(high & low), 32'd0);
`ifdef PWM_DT_BREAK_EN
    chk("latch", 32'(brk_lat), 32'(m_lat));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
    upd = 1'b0;
  endtask

  // Drive channel ch to lvl and count both-off clocks until the target side turns on.
  task automatic gap(int ch, bit lvl, int exp, string tag, int mid_rise);
    int g;
    pwm[ch] = lvl;
    step();
    g = 0;
    while (!(lvl ? high[ch] : low[ch]) && g < 300) begin
      if (g == 0 && mid_rise >= 0) begin rise_pre = W'(mid_rise); upd = 1'b1; end
      g++;
      step();
    end
    chk(tag, 32'(g), 32'(exp));
  endtask

  task automatic shadows(int r, int f, logic [N-1:0] e);
    rise_pre = W'(r); fall_pre = W'(f); en_pre = e; upd = 1'b1;
    step();
  endtask

  initial begin
    #200_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic seen;
    rst_n = 1'b0; upd = 1'b0; pwm = '0; break_i = 1'b0;
    rise_pre = '0; fall_pre = '0; en_pre = '0;
    model_reset();
    @(negedge clk);
    chk("rst_high", 32'(high), 32'd0);
    chk("rst_low", 32'(low), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    shadows(3, 5, '1);
    chk("init_low", 32'(low), 32'h7);
    chk("init_high", 32'(high), 32'h0);

    pwm[1] = 1'b1;
    gap(0, 1'b1, 3, "gap_rise0", -1);
    gap(1, 1'b0, 5, "gap_fall1", -1);

    pwm[2] = 1'b1; step(); step(); pwm[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin step(); seen |= high[2]; end
    chk("swallow2", 32'(seen), 32'd0);

    shadows(0, 0, '1);
    pwm = 3'b101; step();
    chk("bypass_h", 32'(high), 32'h5);
    chk("bypass_l", 32'(low), 32'h2);
    repeat (30) begin pwm = N'($urandom); step(); end

    pwm = '0;
    shadows(3, 0, '1);
    step();
    gap(0, 1'b1, 3, "gap_mid", 7);
    gap(0, 1'b0, 0, "gap_fall0", -1);
    gap(0, 1'b1, 7, "gap_next", -1);

    shadows(7, 0, 3'b101);
    chk("en_off1", 32'({high[1], low[1]}), 32'd0);
    chk("en_on0", 32'(high[0]), 32'd1);

    for (int i = 0; i < 700; i++) begin
      pwm = N'($urandom);
      if ($urandom_range(15) == 0) begin
        rise_pre = ($urandom_range(7) == 0) ? 8'hFF : W'($urandom_range(5));
        fall_pre = W'($urandom_range(5));
        en_pre   = N'($urandom);
        upd      = 1'b1;
      end
      step();
      if ($urandom_range(120) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("arst_out", 32'({high, low}), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
      end
    end

`ifdef PWM_DT_BREAK_EN
    shadows(1, 1, '1);
    pwm = '1;
    repeat (4) step();
    break_i = 1'b1; step(); break_i = 1'b0;
    chk("brk_zero", 32'({high, low}), 32'd0);
    chk("brk_set", 32'(brk_lat), 32'd1);
    repeat (5) step();
    chk("brk_hold", 32'({high, low}), 32'd0);
    shadows(1, 1, '1);
    chk("brk_clr", 32'(brk_lat), 32'd0);
    repeat (4) step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
